// File: rtl/deskew_if.sv
// Bus between the systolic array output, the deskew stage and the output SRAM.
// The master side is the array/sequencer; the slave side is deskew_array.
interface deskew_if #(
  parameter int N    = 8,
  parameter int DW   = 8,
  parameter int ROWS = 8
);
  localparam int AW = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic                  start;
  logic [N-1:0][DW-1:0]  din;
  logic                  din_valid;
  logic [N-1:0][DW-1:0]  dout;
  logic                  wen_n;
  logic [AW-1:0]         waddr;
  logic                  busy;
  logic                  done;

  modport master (
    output start, din, din_valid,
    input  dout, wen_n, waddr, busy, done
  );

  modport slave (
    input  start, din, din_valid,
    output dout, wen_n, waddr, busy, done
  );
endinterface

// File: rtl/deskew_array.sv
// Output de-skewer: aligns diagonally arriving lanes into rows and writes them to SRAM.
// Optional macro DESKEW_RELU_EN clamps negative (signed) lanes to zero on dout.
//
// state | meaning
// IDLE  | waiting for start; din_valid ignored
// RUN   | accepting up to ROWS rows and writing aligned rows
// DONE  | one-cycle done pulse, then back to IDLE
module deskew_array #(
  parameter int N    = 8,
  parameter int DW   = 8,
  parameter int ROWS = 8
) (
  input  logic     clk,
  input  logic     rst,
  deskew_if.slave  bus
);
  localparam int AW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = $clog2(ROWS + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state;
  logic [N-2:0]         vpipe;
  logic [CW-1:0]        accepted;
  logic [AW-1:0]        waddr_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 acc;
  logic                 aval;
  logic [N-1:0][DW-1:0] raw;
  logic [N-1:0][DW-1:0] dout_c;

  assign acc  = bus.din_valid && (state == RUN) && (accepted < CW'(ROWS));
  assign aval = vpipe[N-2];

  // Lane i needs N-1-i stages so that every lane of a row exits together.
  for (genvar i = 0; i < N - 1; i++) begin : g_lane
    localparam int D = N - 1 - i;
    logic [DW-1:0] sr [D];

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int s = 0; s < D; s++) sr[s] <= '0;
      end else begin
        sr[0] <= bus.din[i];
        for (int s = 1; s < D; s++) sr[s] <= sr[s-1];
      end
    end

    assign raw[i] = sr[D-1];
  end
  assign raw[N-1] = bus.din[N-1];

  always_comb begin
    dout_c = raw;
`ifdef DESKEW_RELU_EN
    for (int i = 0; i < N; i++) begin
      if (raw[i][DW-1]) dout_c[i] = '0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      vpipe    <= '0;
      accepted <= '0;
      waddr_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      vpipe[0] <= acc;
      for (int s = 1; s < N - 1; s++) vpipe[s] <= vpipe[s-1];
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            state    <= RUN;
            busy_q   <= 1'b1;
            accepted <= '0;
            waddr_q  <= '0;
            vpipe    <= '0;
          end
        end
        RUN: begin
          if (acc) accepted <= accepted + CW'(1);
          if (aval) begin
            // Address holds on the final row so it still names the last write.
            if (waddr_q == AW'(ROWS - 1)) begin
              state  <= DONE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end else begin
              waddr_q <= waddr_q + AW'(1);
            end
          end
        end
        DONE: begin
          done_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.dout  = dout_c;
  assign bus.wen_n = ~(aval && (state == RUN));
  assign bus.waddr = waddr_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
endmodule
